// File: rtl/mod_ctrl_pkg.sv
// Shared constants for the modular add/subtract sequencer: default width,
// operation encodings and the FSM state encoding.
package mod_ctrl_pkg;

    localparam int MOD_WIDTH = 1025;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE1 = 3'd1;
    localparam logic [2:0] S_WAIT1  = 3'd2;
    localparam logic [2:0] S_ISSUE2 = 3'd3;
    localparam logic [2:0] S_WAIT2  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_ISSUE1 = S_ISSUE1,
        ST_WAIT1  = S_WAIT1,
        ST_ISSUE2 = S_ISSUE2,
        ST_WAIT2  = S_WAIT2,
        ST_FINISH = S_FINISH
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Sequences the shared multi-cycle adder to compute (a+b) mod M or (a-b) mod M.
// Define MOD_CONST_TIME_EN to make subtraction always use two adder operations.
module mod_addsub_ctrl
    import mod_ctrl_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_result,
    input  logic             add_done,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             op_q, op_d;
    logic             add_start_q, add_start_d;
    logic             add_sub_q, add_sub_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Every output is a register loaded from the current state, so the adder
    // sees start and operands together one cycle after the ISSUE state.
    // b_q is reused to hold the second operand once the first op completes.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        m_d         = m_q;
        r_d         = r_q;
        op_d        = op_q;
        add_start_d = 1'b0;
        add_sub_d   = add_sub_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        result_d    = result_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = start && !busy_q;
                if (start && !busy_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    m_d     = in_m;
                    op_d    = op_sub;
                    state_d = ST_ISSUE1;
                end
            end
            ST_ISSUE1: begin
                add_start_d = 1'b1;
                add_a_d     = a_q;
                add_b_d     = b_q;
                add_sub_d   = op_q;
                state_d     = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (add_done) begin
                    r_d = add_result[WIDTH-1:0];
                    if (op_q == OP_ADD || add_result[WIDTH]) begin
                        b_d     = m_q;
                        state_d = ST_ISSUE2;
                    end else begin
`ifdef MOD_CONST_TIME_EN
                        b_d     = '0;
                        state_d = ST_ISSUE2;
`else
                        result_d = add_result[WIDTH-1:0];
                        state_d  = ST_FINISH;
`endif
                    end
                end
            end
            ST_ISSUE2: begin
                add_start_d = 1'b1;
                add_a_d     = r_q;
                add_b_d     = b_q;
                add_sub_d   = (op_q == OP_ADD);
                state_d     = ST_WAIT2;
            end
            ST_WAIT2: begin
                // A negative r-M means a+b was already reduced.
                if (add_done) begin
                    if (op_q == OP_ADD && add_result[WIDTH]) begin
                        result_d = r_q;
                    end else begin
                        result_d = add_result[WIDTH-1:0];
                    end
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            m_q         <= '0;
            r_q         <= '0;
            op_q        <= 1'b0;
            add_start_q <= 1'b0;
            add_sub_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            m_q         <= m_d;
            r_q         <= r_d;
            op_q        <= op_d;
            add_start_q <= add_start_d;
            add_sub_q   <= add_sub_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign add_start    = add_start_q;
    assign add_subtract = add_sub_q;
    assign add_a        = add_a_q;
    assign add_b        = add_b_q;
    assign result       = result_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Randomized self-checking bench for mod_addsub_ctrl with a behavioural adder
// of programmable latency; honours MOD_CONST_TIME_EN in its expectations.
module tb_mod_addsub_ctrl;
    import mod_ctrl_pkg::*;

    localparam int W = MOD_WIDTH;
    typedef logic [W:0] wide_t;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         opSub = 1'b0;
    logic [W-1:0] inA = '0;
    logic [W-1:0] inB = '0;
    logic [W-1:0] inM = '0;
    logic         addStart, addSubtract, addDone, done, busy;
    logic [W-1:0] addA, addB, result;
    logic [W:0]   addResult;

    logic         modelDone;
    logic         noiseDone = 1'b0;
    logic [W:0]   pending;
    logic         adderBusy;
    int           adderCnt;
    int           adderLat = 3;
    int           startPulses = 0;
    int           overlapCnt = 0;
    int           cyc = 0;
    int           checks = 0;
    int           fails = 0;

    assign addDone = modelDone | noiseDone;

    mod_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op_sub(opSub),
        .in_a(inA), .in_b(inB), .in_m(inM),
        .add_start(addStart), .add_subtract(addSubtract), .add_a(addA), .add_b(addB),
        .add_result(addResult), .add_done(addDone),
        .result(result), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in adder: add_done rises adderLat edges after add_start rises.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            adderBusy <= 1'b0;
            adderCnt  <= 0;
            modelDone <= 1'b0;
            addResult <= '0;
            pending   <= '0;
        end else begin
            modelDone <= 1'b0;
            if (addStart) begin
                if (adderBusy) overlapCnt <= overlapCnt + 1;
                startPulses <= startPulses + 1;
                adderBusy   <= 1'b1;
                adderCnt    <= adderLat - 2;
                pending     <= addSubtract ? ({1'b0, addA} - {1'b0, addB})
                                           : ({1'b0, addA} + {1'b0, addB});
            end else if (adderBusy) begin
                if (adderCnt == 0) begin
                    modelDone <= 1'b1;
                    addResult <= pending;
                    adderBusy <= 1'b0;
                end else begin
                    adderCnt <= adderCnt - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, want %0h (low 256 bits)", tag, observed[255:0], expected[255:0]);
        end
    endtask

    function automatic wide_t randBits(input int nbits);
        wide_t v;
        wide_t mask;
        v = '0;
        for (int i = 0; i < 33; i++) v = (v << 32) | wide_t'($urandom());
        mask = wide_t'(1);
        mask = (mask << nbits) - wide_t'(1);
        return v & mask;
    endfunction

    // Runs one operation from an idle DUT and checks result, pulses, latency, handshake.
    task automatic applyStimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] m, input logic op, input int lat);
        wide_t expRes;
        int    expPulses, expLat, pulses0, acceptCyc, waitCnt;
        bit    seen;
        if (op == OP_ADD) expRes = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
        else              expRes = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
        expPulses = (op == OP_ADD || a < b) ? 2 : 1;
`ifdef MOD_CONST_TIME_EN
        expPulses = 2;
`endif
        expLat   = (expPulses == 2) ? 2 * lat + 5 : lat + 3;
        adderLat = lat;
        @(negedge clk);
        inA = a; inB = b; inM = m; opSub = op; start = 1'b1;
        pulses0 = startPulses;
        @(negedge clk);
        start = 1'b0;
        acceptCyc = cyc;
        inA = ~a; inB = ~b; inM = ~m; opSub = ~op;
        checkOutput({tag, " busy after accept"}, wide_t'(busy), wide_t'(1));
        seen = 0;
        waitCnt = 0;
        while (!seen && waitCnt < 200) begin
            if (done) seen = 1;
            else begin
                @(negedge clk);
                waitCnt++;
            end
        end
        checkOutput({tag, " done seen"}, wide_t'(seen), wide_t'(1));
        if (seen) begin
            checkOutput({tag, " result"}, wide_t'(result), expRes);
            checkOutput({tag, " latency"}, wide_t'(cyc - acceptCyc), wide_t'(expLat));
            checkOutput({tag, " add_start pulses"}, wide_t'(startPulses - pulses0), wide_t'(expPulses));
            checkOutput({tag, " busy in done cycle"}, wide_t'(busy), wide_t'(1));
            @(negedge clk);
            checkOutput({tag, " done one cycle"}, wide_t'(done), wide_t'(0));
            checkOutput({tag, " busy falls"}, wide_t'(busy), wide_t'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] a, b, m, big;
        logic [W-1:0] held;
        wide_t        mw;
        int           nbits, waitCnt, p0, doneCnt;

        repeat (2) @(negedge clk);
        checkOutput("reset busy", wide_t'(busy), wide_t'(0));
        checkOutput("reset done", wide_t'(done), wide_t'(0));
        checkOutput("reset result", wide_t'(result), wide_t'(0));
        checkOutput("reset adder drive", wide_t'({addStart, addSubtract, addA | addB}), wide_t'(0));
        resetn = 1'b1;

        applyStimulus("7+9 mod 13", 7, 9, 13, OP_ADD, 3);
        applyStimulus("5-8 mod 13", 5, 8, 13, OP_SUB, 4);
        applyStimulus("6+7 mod 13", 6, 7, 13, OP_ADD, 2);
        applyStimulus("4-4 mod 13", 4, 4, 13, OP_SUB, 3);
        applyStimulus("9-2 mod 13", 9, 2, 13, OP_SUB, 5);
        applyStimulus("0+0 mod 13", 0, 0, 13, OP_ADD, 2);

        // Stray add_done while idle must not disturb anything.
        held = result;
        @(negedge clk) noiseDone = 1'b1;
        @(negedge clk) noiseDone = 1'b0;
        @(negedge clk);
        checkOutput("stray add_done busy", wide_t'(busy), wide_t'(0));
        checkOutput("stray add_done result", wide_t'(result), wide_t'(held));

        // start held high: one done per op, re-accept only once busy is low.
        adderLat = 2;
        doneCnt = 0;
        @(negedge clk);
        inA = 7; inB = 9; inM = 13; opSub = OP_ADD; start = 1'b1;
        waitCnt = 0;
        while (waitCnt < 300 && doneCnt < 2) begin
            @(negedge clk);
            waitCnt++;
            if (done) begin
                doneCnt++;
                checkOutput("held start result", wide_t'(result), wide_t'(3));
                @(negedge clk);
                checkOutput("held start no accept in done cycle", wide_t'(busy), wide_t'(0));
                @(negedge clk);
                if (doneCnt == 1) checkOutput("held start re-accept", wide_t'(busy), wide_t'(1));
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("held start done count", wide_t'(doneCnt), wide_t'(2));
        @(negedge clk);
        waitCnt = 0;
        while (busy && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("held start drains", wide_t'(busy), wide_t'(0));

        // Asynchronous reset while the second adder op is outstanding.
        adderLat = 4;
        @(negedge clk);
        inA = 7; inB = 9; inM = 13; opSub = OP_ADD; start = 1'b1;
        p0 = startPulses;
        @(negedge clk) start = 1'b0;
        waitCnt = 0;
        while (startPulses - p0 < 2 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("reset test reached WAIT2", wide_t'(startPulses - p0), wide_t'(2));
        #2 resetn = 1'b0;
        #1;
        checkOutput("async reset busy", wide_t'(busy), wide_t'(0));
        checkOutput("async reset done", wide_t'(done), wide_t'(0));
        checkOutput("async reset result", wide_t'(result), wide_t'(0));
        checkOutput("async reset adder drive", wide_t'({addStart, addSubtract, addA | addB}), wide_t'(0));
        @(negedge clk) resetn = 1'b1;
        applyStimulus("12+12 mod 13 after reset", 12, 12, 13, OP_ADD, 3);

        big = '0;
        big[W-2] = 1'b1;
        applyStimulus("full width add", big, big, big | 1, OP_ADD, 3);
        applyStimulus("full width sub", 0, big, big | 1, OP_SUB, 2);

        for (int i = 0; i < 40; i++) begin
            nbits = (i % 2 == 0) ? $urandom_range(2, 16) : $urandom_range(17, W - 1);
            mw = randBits(nbits);
            if (mw == 0) mw = 1;
            m = mw[W-1:0];
            mw = randBits(W) % {1'b0, m};
            a = mw[W-1:0];
            mw = randBits(W) % {1'b0, m};
            b = ($urandom_range(0, 7) == 0) ? a : mw[W-1:0];
            applyStimulus($sformatf("random op %0d", i), a, b, m, 1'($urandom_range(0, 1)), $urandom_range(2, 5));
        end

        checkOutput("no add_start while outstanding", wide_t'(overlapCnt), wide_t'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
